// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC width, sequencer states and next-PC source select.
package cpu_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned INC_DEFAULT = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_INC    = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_BRANCH = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection with word alignment; flags redirect targets whose low bits are set.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int unsigned INC = INC_DEFAULT
) (
  input  logic [PC_W-1:0] pc_i,
  input  pc_sel_t         sel_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic [PC_W-1:0] branch_offset_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic            misalign_o
);

  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  logic [PC_W-1:0] target;

  always_comb begin
    target     = '0;
    pc_next_o  = pc_i;
    misalign_o = 1'b0;
    case (sel_i)
      SEL_HOLD: pc_next_o = pc_i;
      SEL_INC:  pc_next_o = pc_i + INC_V;
      SEL_JUMP: begin
        target     = jump_target_i;
        pc_next_o  = {target[PC_W-1:2], 2'b00};
        misalign_o = |target[1:0];
      end
      SEL_BRANCH: begin
        // Offset is two's complement, so a plain modular add covers both directions.
        target     = pc_i + branch_offset_i;
        pc_next_o  = {target[PC_W-1:2], 2'b00};
        misalign_o = |target[1:0];
      end
      default: pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register and BOOT/RUN/STALL/HALT control FSM.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = 16'h0000,
  parameter int unsigned     INC       = INC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_instr,
  input  logic            resume,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_Next,
  output logic            fetch_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [1:0]      state
);

  pc_state_t       state_q, state_d;
  pc_sel_t         sel;
  logic [PC_W-1:0] pc_q, pc_d, mux_pc;
  logic            misalign_q, misalign_d, mux_misalign;

  pc_next_mux #(
    .INC (INC)
  ) u_next_mux (
    .pc_i            (pc_q),
    .sel_i           (sel),
    .jump_target_i   (jump_target),
    .branch_offset_i (branch_offset),
    .pc_next_o       (mux_pc),
    .misalign_o      (mux_misalign)
  );

  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (stall)             state_d = STALL;
        else if (halt_instr)   state_d = HALT;
        else if (jump)         sel     = SEL_JUMP;
        else if (branch_taken) sel     = SEL_BRANCH;
        else                   sel     = SEL_INC;
      end
      STALL: if (!stall) state_d = RUN;
      HALT: begin
        if (resume) begin
          state_d = RUN;
          sel     = SEL_INC;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // PC_Next reports the value actually loaded, so reset is folded in here too.
  assign pc_d       = rst ? RESET_VEC : mux_pc;
  assign misalign_d = misalign_q | mux_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign PC           = pc_q;
  assign PC_Next      = pc_d;
  assign fetch_valid  = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;
  assign state        = state_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 16'h0000: PC value loaded by reset.
REQ-002 Parameter INC, default 4: sequential PC increment in bytes.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 stall  input  1  freeze request from the datapath; holds PC.
REQ-006 halt_instr  input  1  current instruction decoded as HALT.
REQ-007 resume  input  1  release from HALT.
REQ-008 jump  input  1  absolute redirect request.
REQ-009 jump_target  input  16  absolute target address.
REQ-010 branch_taken  input  1  relative redirect request.
REQ-011 branch_offset  input  16  signed byte offset, relative to current PC.
REQ-012 PC  output  16  registered address of the current instruction.
REQ-013 PC_Next  output  16  combinational value PC takes at the next edge.
REQ-014 fetch_valid  output  1  PC addresses a valid instruction this cycle.
REQ-015 halted  output  1  high while in HALT.
REQ-016 misalign_err  output  1  sticky flag: redirect target had addr[1:0] != 0.
REQ-017 state  output  2  current FSM state, for debug.

Function
REQ-018 FSM states: BOOT=0, RUN=1, STALL=2, HALT=3.
REQ-019 BOOT: lasts exactly one cycle after rst falls; PC=RESET_VEC; fetch_valid=0; next state is RUN with PC unchanged.
REQ-020 RUN input priority, highest first: stall > halt_instr > jump > branch_taken > sequential.
REQ-021 RUN, stall=1: go to STALL; PC holds; all other control inputs ignored that cycle.
REQ-022 RUN, halt_instr=1: go to HALT; PC holds at the HALT address.
REQ-023 RUN, jump=1: PC <= {jump_target[15:2],2'b00}.
REQ-024 RUN, branch_taken=1: PC <= PC + branch_offset, taken modulo 2^16, with bits [1:0] forced to 0.
REQ-025 RUN, no request: PC <= PC + INC, modulo 2^16; 16'hFFFC wraps to 16'h0000.
REQ-026 STALL: PC holds; fetch_valid=0; control inputs ignored; return to RUN on the first cycle with stall=0, with no PC change on that edge.
REQ-027 HALT: PC holds; halted=1; fetch_valid=0; stall ignored; resume=1 gives PC <= PC + INC and RUN on the next edge.
REQ-028 fetch_valid=1 only in RUN.
REQ-029 Redirect latency: one edge; the new PC is visible in the cycle after the request.
REQ-030 PC_Next equals PC in BOOT, STALL and HALT except on the resume cycle; in all cases PC_Next equals the value PC takes at the next edge.
REQ-031 misalign_err sets when a taken jump or branch target has nonzero bits [1:0]; it stays set until rst.

Reset
REQ-032 rst=1 at an edge: PC=RESET_VEC, state=BOOT, fetch_valid=0, halted=0, misalign_err=0.
REQ-033 rst overrides every other input in every state, including STALL and HALT mid-operation.
REQ-034 No output is X after the first reset edge.

Structure
REQ-035 Shared package cpu_pkg holds: PC_W=16, pc_state_t enum (BOOT/RUN/STALL/HALT), and the default INC constant.
REQ-036 Next-PC selection and alignment logic live in one combinational sub-module, pc_next_mux.
REQ-037 The PC register and FSM live in pc_sequencer.

Verification
REQ-038 Hold rst for 2 cycles, then release with no requests: PC sequence 0000, 0000 (BOOT), 0004, 0008; fetch_valid low in BOOT.
REQ-039 At PC=0008, jump=1 with jump_target=0040: next PC=0040; then apply branch_offset=FFF8 with branch_taken=1: next PC=0038.
REQ-040 At PC=0010, assert stall for 3 cycles together with jump=1: PC stays 0010 and fetch_valid=0; after release, one hold cycle, then PC=0014; the jump is ignored.
REQ-041 halt_instr at PC=0020: halted=1 and PC stays 0020 for 5 cycles; resume gives PC=0024, RUN, halted=0.
REQ-042 Run sequentially from PC=FFF8: PC goes FFFC then 0000; a jump to 0042 gives PC=0040 and misalign_err=1, which stays set until rst.
REQ-043 Assert rst while in HALT and while in STALL: on the next edge PC=RESET_VEC, state=BOOT, all flags cleared.
